econet_fcs_checker: RTL

Frame checker on the receive path, directly downstream of the Econet receiver. Consumes the 9-bit token stream that the receiver produces: bit 8 = raw/flag marker, bits 7:0 = byte. Delimits frames on flag tokens, checks the HDLC CRC-16 FCS, strips the two FCS bytes, forwards payload bytes with valid/ready, and reports per-frame status.

---
 rtl/econet_fcs_checker_if.sv | 30 +++
 rtl/econet_fcs_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/econet_fcs_checker_if.sv
// Econet frame-checker stream bundle.
// Groups the token input stream (in_valid/in_data/in_ready), the payload
// output stream (out_valid/out_data/out_first/out_ready) and the per-frame
// status report (frame_done/frame_status/frame_len).
//   slave  : view taken by the checker itself.
//   master : view taken by whoever feeds tokens and drains payload.
interface econet_fcs_checker_if;
    logic        in_valid;
    logic [8:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_first;
    logic        out_ready;
    logic        frame_done;
    logic [2:0]  frame_status;
    logic [10:0] frame_len;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_first,
        output frame_done, frame_status, frame_len
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_first,
        input  frame_done, frame_status, frame_len
    );
endinterface

// File: rtl/econet_fcs_checker.sv
// Econet receive-path frame checker.
// Consumes 9-bit receiver tokens (bit 8 = raw marker; 0x17E flag, other raw =
// abort, 0x0xx data byte), delimits frames on flags, checks the HDLC CRC-16
// FCS, strips the two FCS bytes and forwards payload with valid/ready.
// Ports:
//   clock_24m : system clock, rising edge.
//   nRESET    : synchronous active-low reset.
//   bus       : econet_fcs_checker_if.slave (token in, payload out, status).
// Parameters:
//   MIN_LEN   : minimum payload bytes (excluding FCS) for a good frame.
//   MAX_LEN   : maximum payload bytes (excluding FCS); more ends the frame.
module econet_fcs_checker #(
    parameter int unsigned MIN_LEN = 2,
    parameter int unsigned MAX_LEN = 1280
) (
    input  logic                 clock_24m,
    input  logic                 nRESET,
    econet_fcs_checker_if.slave  bus
);
    typedef enum logic {
        HUNT,
        FRAME
    } state_t;

    localparam logic [8:0]  FLAG_TOK    = 9'h17E;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'h8408;
    localparam logic [15:0] CRC_RESIDUE = 16'hF0B8;
    localparam logic [11:0] MIN_CNT     = 12'(MIN_LEN + 2);
    localparam logic [11:0] MAX_CNT     = 12'(MAX_LEN + 2);
    localparam logic [10:0] MAX_LEN_W   = 11'(MAX_LEN);

    localparam logic [2:0] ST_GOOD  = 3'd0;
    localparam logic [2:0] ST_FCS   = 3'd1;
    localparam logic [2:0] ST_SHORT = 3'd2;
    localparam logic [2:0] ST_ABORT = 3'd3;
    localparam logic [2:0] ST_LONG  = 3'd4;

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [10:0] count_q, count_d;
    logic [7:0]  d0_q, d0_d;        // newest byte in the delay line
    logic [7:0]  d1_q, d1_d;        // oldest byte in the delay line
    logic [1:0]  fill_q, fill_d;    // delay line occupancy, 0..2
    logic        first_q, first_d;
    logic        ov_q, ov_d;
    logic [7:0]  od_q, od_d;
    logic        of_q, of_d;
    logic        done_q, done_d;
    logic [2:0]  status_q, status_d;
    logic [10:0] len_q, len_d;

    logic        accept;
    logic        tok_flag;
    logic        tok_raw;
    logic [15:0] crc_next;
    logic [11:0] count_inc;
    logic [10:0] len_sat;

    assign bus.in_ready     = nRESET && (!ov_q || bus.out_ready);
    assign bus.out_valid    = ov_q;
    assign bus.out_data     = od_q;
    assign bus.out_first    = of_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_status = status_q;
    assign bus.frame_len    = len_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign tok_flag  = (bus.in_data == FLAG_TOK);
    assign tok_raw   = bus.in_data[8];
    assign count_inc = {1'b0, count_q} + 12'd1;
    assign len_sat   = (count_q >= 11'd2) ? (count_q - 11'd2) : '0;

    // Reflected CCITT, one full byte per cycle.
    always_comb begin
        crc_next = crc_q ^ {8'h00, bus.in_data[7:0]};
        for (int unsigned i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
        end
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        count_d  = count_q;
        d0_d     = d0_q;
        d1_d     = d1_q;
        fill_d   = fill_q;
        first_d  = first_q;
        ov_d     = ov_q;
        od_d     = od_q;
        of_d     = of_q;
        done_d   = 1'b0;
        status_d = status_q;
        len_d    = len_q;

        if (ov_q && bus.out_ready) begin
            ov_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (tok_flag) begin
                        state_d = FRAME;
                        crc_d   = CRC_INIT;
                        count_d = '0;
                        fill_d  = '0;
                        first_d = 1'b1;
                    end
                end

                FRAME: begin
                    if (tok_flag) begin
                        // A closing flag doubles as the next opening flag.
                        if (count_q != '0) begin
                            done_d = 1'b1;
                            len_d  = len_sat;
                            if ({1'b0, count_q} < MIN_CNT) begin
                                status_d = ST_SHORT;
                            end else if (crc_q != CRC_RESIDUE) begin
                                status_d = ST_FCS;
                            end else begin
                                status_d = ST_GOOD;
                            end
                        end
                        crc_d   = CRC_INIT;
                        count_d = '0;
                        fill_d  = '0;
                        first_d = 1'b1;
                    end else if (tok_raw) begin
                        if (count_q != '0) begin
                            done_d   = 1'b1;
                            status_d = ST_ABORT;
                            len_d    = len_sat;
                        end
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (count_inc > MAX_CNT) begin
                        done_d   = 1'b1;
                        status_d = ST_LONG;
                        len_d    = MAX_LEN_W;
                        state_d  = HUNT;
                        fill_d   = '0;
                    end else begin
                        crc_d   = crc_next;
                        count_d = count_inc[10:0];
                        d0_d    = bus.in_data[7:0];
                        d1_d    = d0_q;
                        // Only bytes two positions behind the newest can be
                        // payload; the last two of a frame are its FCS.
                        if (fill_q == 2'd2) begin
                            ov_d    = 1'b1;
                            od_d    = d1_q;
                            of_d    = first_q;
                            first_d = 1'b0;
                        end else begin
                            fill_d = fill_q + 2'd1;
                        end
                    end
                end

                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock_24m) begin
        if (!nRESET) begin
            state_q  <= HUNT;
            crc_q    <= CRC_INIT;
            count_q  <= '0;
            d0_q     <= '0;
            d1_q     <= '0;
            fill_q   <= '0;
            first_q  <= 1'b1;
            ov_q     <= 1'b0;
            od_q     <= '0;
            of_q     <= 1'b0;
            done_q   <= 1'b0;
            status_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            count_q  <= count_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            fill_q   <= fill_d;
            first_q  <= first_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            of_q     <= of_d;
            done_q   <= done_d;
            status_q <= status_d;
            len_q    <= len_d;
        end
    end
endmodule
